// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - register-file write-back stage (optional WB_OPCODE_FILTER_EN)
module writeback_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode,
    input  logic [XLEN-1:0] alu_out,
    input  logic            wb_reg,
    input  logic [XLEN-1:0] dcache_out,
    input  logic            done,
    output logic [XLEN-1:0] wb_rd_data,
    output logic            wb_enable
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [XLEN-1:0] wb_rd_data_q, wb_rd_data_d;
    logic            wb_enable_q, wb_enable_d;
    logic            is_load;
    logic            writes_rd;

    assign is_load = (opcode == OPC_LOAD);

`ifdef WB_OPCODE_FILTER_EN
    // Only opcodes that architecturally produce an rd value may write.
    always_comb begin
        writes_rd = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_OP, OPC_JAL,
            OPC_JALR, OPC_LUI, OPC_AUIPC: writes_rd = 1'b1;
            default:                      writes_rd = 1'b0;
        endcase
    end
`else
    assign writes_rd = 1'b1;
`endif

    always_comb begin
        wb_rd_data_d = is_load ? dcache_out : alu_out;
        wb_enable_d  = wb_reg & (~is_load | done) & writes_rd;
    end

    // Data register updates every cycle; only the strobe qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_rd_data_q <= '0;
            wb_enable_q  <= 1'b0;
        end else begin
            wb_rd_data_q <= wb_rd_data_d;
            wb_enable_q  <= wb_enable_d;
        end
    end

    assign wb_rd_data = wb_rd_data_q;
    assign wb_enable  = wb_enable_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed-vector bench for writeback_stage
module tb_writeback_stage;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] ALU_V = 32'h0001_0000;
    localparam logic [31:0] DC_V  = 32'h0000_0101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [31:0] alu_out;
    logic        wb_reg;
    logic [31:0] dcache_out;
    logic        done;
    logic [31:0] wb_rd_data;
    logic        wb_enable;

    int vectors = 0;
    int miscompares = 0;

    writeback_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_out(alu_out),
        .wb_reg(wb_reg), .dcache_out(dcache_out), .done(done),
        .wb_rd_data(wb_rd_data), .wb_enable(wb_enable)
    );

    always #5 clk = ~clk;

    // Drive one instruction, then sample 1 ns after the capturing edge.
    task automatic apply(input logic [6:0] op, input logic wr, input logic dn);
        opcode = op;
        wb_reg = wr;
        done   = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        opcode = OPC_OP; wb_reg = 1'b1; done = 1'b1;
        alu_out = ALU_V; dcache_out = DC_V;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (wb_rd_data !== 32'h0 || wb_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: data=%h en=%b required data=00000000 en=0", wb_rd_data, wb_enable);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_load();
        apply(OPC_LOAD, 1'b1, 1'b1);
        vectors++;
        if (wb_rd_data !== DC_V || wb_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL load_done: data=%h en=%b required data=%h en=1", wb_rd_data, wb_enable, DC_V);
        end
        apply(OPC_LOAD, 1'b1, 1'b0);
        vectors++;
        if (wb_rd_data !== DC_V || wb_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL load_not_done: data=%h en=%b required data=%h en=0", wb_rd_data, wb_enable, DC_V);
        end
        // done rises with new load data: commit uses data sampled at that edge
        dcache_out = 32'hCAFE_0042;
        apply(OPC_LOAD, 1'b1, 1'b1);
        vectors++;
        if (wb_rd_data !== 32'hCAFE_0042 || wb_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL load_done_rise: data=%h en=%b required data=cafe0042 en=1", wb_rd_data, wb_enable);
        end
        dcache_out = DC_V;
    endtask

    task automatic test_no_write();
        logic [6:0] ops [2];
        ops[0] = OPC_STORE; ops[1] = OPC_BRANCH;
        for (int i = 0; i < 2; i++) begin
            apply(ops[i], 1'b0, 1'b1);
            vectors++;
            if (wb_rd_data !== ALU_V || wb_enable !== 1'b0) begin
                miscompares++;
                $display("FAIL no_write_op%b: data=%h en=%b required data=%h en=0", ops[i], wb_rd_data, wb_enable, ALU_V);
            end
        end
    endtask

    task automatic test_alu_ops();
        logic [6:0] ops [6];
        ops[0] = OPC_OP_IMM; ops[1] = OPC_OP;  ops[2] = OPC_JAL;
        ops[3] = OPC_JALR;   ops[4] = OPC_LUI; ops[5] = OPC_AUIPC;
        for (int i = 0; i < 6; i++) begin
            for (int d = 1; d >= 0; d--) begin
                apply(ops[i], 1'b1, d[0]);
                vectors++;
                if (wb_rd_data !== ALU_V || wb_enable !== 1'b1) begin
                    miscompares++;
                    $display("FAIL alu_op%b_done%0d: data=%h en=%b required data=%h en=1", ops[i], d, wb_rd_data, wb_enable, ALU_V);
                end
            end
        end
        apply(OPC_OP, 1'b0, 1'b1);
        vectors++;
        if (wb_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL op_no_wbreg: en=%b required en=0", wb_enable);
        end
    endtask

    task automatic test_filter();
        logic exp_en;
`ifdef WB_OPCODE_FILTER_EN
        exp_en = 1'b0;
`else
        exp_en = 1'b1;
`endif
        apply(OPC_STORE, 1'b1, 1'b1);
        vectors++;
        if (wb_rd_data !== ALU_V || wb_enable !== exp_en) begin
            miscompares++;
            $display("FAIL store_wbreg: data=%h en=%b required data=%h en=%b", wb_rd_data, wb_enable, ALU_V, exp_en);
        end
        apply(7'b1111111, 1'b1, 1'b1);
        vectors++;
        if (wb_enable !== exp_en) begin
            miscompares++;
            $display("FAIL unknown_wbreg: en=%b required en=%b", wb_enable, exp_en);
        end
    endtask

    task automatic test_back_to_back();
        apply(OPC_LOAD, 1'b1, 1'b1);
        vectors++;
        if (wb_rd_data !== DC_V || wb_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_load: data=%h en=%b required data=%h en=1", wb_rd_data, wb_enable, DC_V);
        end
        apply(OPC_OP, 1'b1, 1'b1);
        vectors++;
        if (wb_rd_data !== ALU_V || wb_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_op: data=%h en=%b required data=%h en=1", wb_rd_data, wb_enable, ALU_V);
        end
    endtask

    task automatic test_async_reset();
        apply(OPC_LOAD, 1'b1, 1'b1);
        vectors++;
        if (wb_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_async_reset: en=%b required en=1", wb_enable);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (wb_rd_data !== 32'h0 || wb_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: data=%h en=%b required data=00000000 en=0", wb_rd_data, wb_enable);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (wb_rd_data !== 32'h0 || wb_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_replay: data=%h en=%b required data=00000000 en=0", wb_rd_data, wb_enable);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(OPC_OP, 1'b1, 1'b1);
        vectors++;
        if (wb_rd_data !== ALU_V || wb_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_first: data=%h en=%b required data=%h en=1", wb_rd_data, wb_enable, ALU_V);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_no_write();
        test_alu_ops();
        test_filter();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
